// File: rtl/dds_core_if.sv
// rtl/dds_core_if.sv - sweep-generator <-> DDS core signal bundle
interface dds_core_if #(
   parameter int OUT_W = 12
);
   logic             dds_en;
   logic             phase_clr;
   logic [31:0]      dds_fword;
   logic [31:0]      dds_pword;
   logic [31:0]      dds_amp;
   logic [OUT_W-1:0] dds_out;
   logic             dds_valid;
   logic [31:0]      dds_phase;

   modport master (
      output dds_en, phase_clr, dds_fword, dds_pword, dds_amp,
      input  dds_out, dds_valid, dds_phase
   );

   modport slave (
      input  dds_en, phase_clr, dds_fword, dds_pword, dds_amp,
      output dds_out, dds_valid, dds_phase
   );
endinterface

// File: rtl/dds_core.sv
// rtl/dds_core.sv - 5-stage quarter-wave DDS sine generator (optional DDS_CORE_PHASE_DITHER_EN)
module dds_core #(
   parameter int OUT_W  = 12,
   parameter int LUT_AW = 8
) (
   input logic       clk,
   input logic       rstn,
   dds_core_if.slave bus
);

   localparam int AMP_MAX = 2 ** (OUT_W - 1) - 1;
   localparam int LUT_N   = 2 ** LUT_AW;

   // Quarter-wave entry i sampled at bin centre (i+0.5); sine evaluated by Taylor series at elaboration
   function automatic logic [OUT_W-2:0] lut_entry(input int i);
      real x;
      real term;
      real s;
      int  v;
      x    = (real'(i) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUT_AW + 1));
      term = x;
      s    = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      v = int'(real'(AMP_MAX) * s);
      return v[OUT_W-2:0];
   endfunction

   // Constant ROM: built from elaboration-time constants, never touched by reset
   logic [OUT_W-2:0] lut_rom [LUT_N];
   for (genvar g = 0; g < LUT_N; g++) begin : g_lut
      localparam logic [OUT_W-2:0] ENTRY = lut_entry(g);
      assign lut_rom[g] = ENTRY;
   end

   // S1 phase accumulator
   logic [31:0] acc_q, acc_d;
   logic        v1_q;

   // S2 offset phase
   logic [31:0] ph_q, ph_d;
   logic        v2_q;

   // S3 LUT read
   logic [1:0]        quad;
   logic [LUT_AW-1:0] idx_raw;
   logic [LUT_AW-1:0] idx_d;
   logic [OUT_W-2:0]  lut_q;
   logic              neg3_q;
   logic              v3_q;

   // S4 signed sample
   logic [OUT_W-1:0] mag;
   logic [OUT_W-1:0] sample_d, sample_q;
   logic             v4_q;

   // S5 amplitude scaling
   logic [OUT_W+16:0] prod;
   logic [OUT_W-1:0]  out_d, out_q;
   logic              valid_q;

   // Accumulator next state: clear wins over advance, hold when disabled
   always_comb begin
      acc_d = acc_q;
      if (bus.phase_clr) begin
         acc_d = 32'h0000_0000;
      end else if (bus.dds_en) begin
         acc_d = acc_q + bus.dds_fword;
      end
   end

   // S1 accumulator and launch flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= 32'h0000_0000;
         v1_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         v1_q  <= bus.dds_en;
      end
   end

`ifdef DDS_CORE_PHASE_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        lfsr_fb;

   // Dither LFSR (taps 16,14,13,11) steps once per enabled cycle
   always_comb begin
      lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_d  = bus.dds_en ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
   end

   // Dither state register, reseeded on reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign ph_d = acc_q + bus.dds_pword + {16'h0000, lfsr_q};
`else
   assign ph_d = acc_q + bus.dds_pword;
`endif

   // S2 phase offset stage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ph_q <= 32'h0000_0000;
         v2_q <= 1'b0;
      end else begin
         ph_q <= ph_d;
         v2_q <= v1_q;
      end
   end

   // Odd quadrants walk the quarter wave backwards, so the index is mirrored
   assign quad    = ph_q[31:30];
   assign idx_raw = ph_q[29:30-LUT_AW];
   assign idx_d   = quad[0] ? ~idx_raw : idx_raw;

   // S3 registered ROM read; only the sign half of the quadrant is still needed
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lut_q  <= '0;
         neg3_q <= 1'b0;
         v3_q   <= 1'b0;
      end else begin
         lut_q  <= lut_rom[idx_d];
         neg3_q <= quad[1];
         v3_q   <= v2_q;
      end
   end

   assign mag      = {1'b0, lut_q};
   assign sample_d = neg3_q ? (~mag + 1'b1) : mag;

   // S4 signed sample register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sample_q <= '0;
         v4_q     <= 1'b0;
      end else begin
         sample_q <= sample_d;
         v4_q     <= v3_q;
      end
   end

   // Both operands widened to the full product width; dropping the low 16 bits is a floor shift
   assign prod  = {{17{sample_q[OUT_W-1]}}, sample_q} * {{OUT_W{1'b0}}, 1'b0, bus.dds_amp[15:0]};
   assign out_d = prod[OUT_W+15:16];

   // S5 output register: only a launched sample updates dds_out, otherwise it holds
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (v4_q) begin
            out_q <= out_d;
         end
         valid_q <= v4_q;
      end
   end

   assign bus.dds_out   = out_q;
   assign bus.dds_valid = valid_q;
   assign bus.dds_phase = acc_q;

   logic unused_bits;
   assign unused_bits = ^{bus.dds_amp[31:16], ph_q[29-LUT_AW:0], prod[15:0], prod[OUT_W+16]};

endmodule

// File: tb/tb_dds_core.sv
// tb/tb_dds_core.sv - scoreboard bench for dds_core against an ideal sine model
module tb_dds_core;

   localparam int OUT_W  = 12;
   localparam int LUT_AW = 8;
   localparam int AMP_MAX = 2 ** (OUT_W - 1) - 1;

   logic clk;
   logic rstn;

   dds_core_if #(.OUT_W(OUT_W)) bus ();

   dds_core #(.OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] acc;
      logic [31:0] pw;
      int          age;
   } pend_t;

   pend_t       pend[$];
   int          exp_q[$];
   logic [31:0] m_acc;
   int          last_out;
   int          obs_max;
   int          obs_min;

   // Ideal sine of the phase, quantised to the centre of its table bin, then scaled by amp (floor)
   function automatic int model_sample(input logic [31:0] ph, input int amp);
      int     bin;
      real    ang;
      real    s;
      int     mag;
      int     smp;
      longint p;
      bin = int'(ph >> (30 - LUT_AW));
      ang = (real'(bin) + 0.5) * 2.0 * 3.14159265358979323846 / real'(2 ** (LUT_AW + 2));
      s   = $sin(ang);
      mag = int'(real'(AMP_MAX) * (s < 0.0 ? -s : s));
      smp = (s < 0.0) ? -mag : mag;
      p   = longint'(smp) * longint'(amp);
      return int'(p >>> 16);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference model: phase accumulation plus timing of when offset and amplitude are consumed
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_acc = 32'h0;
         pend.delete();
         exp_q.delete();
      end else begin
         for (int i = 0; i < pend.size(); i++) begin
            pend[i].age++;
            if (pend[i].age == 1) pend[i].pw = bus.dds_pword;
         end
         if (pend.size() > 0 && pend[0].age == 4) begin
            exp_q.push_back(model_sample(pend[0].acc + pend[0].pw, int'(bus.dds_amp[15:0])));
            void'(pend.pop_front());
         end
         if (bus.phase_clr) m_acc = 32'h0;
         else if (bus.dds_en) m_acc = m_acc + bus.dds_fword;
         if (bus.dds_en) pend.push_back('{m_acc, 32'h0, 0});
      end
   end

   // Monitor: compares phase every cycle, pops the scoreboard on valid, checks hold otherwise
   always @(negedge clk) begin
      int act;
      int exp;
      if (!rstn) begin
         last_out = 0;
      end else begin
         act = int'($signed(bus.dds_out));
         checks++;
         if (bus.dds_phase !== m_acc) begin
            errors++;
            $display("FAIL phase actual=%h expected=%h", bus.dds_phase, m_acc);
         end
         checks++;
         if ((bus.dds_valid ? 1 : 0) != exp_q.size()) begin
            errors++;
            $display("FAIL valid_timing actual=%0b expected_pending=%0d", bus.dds_valid, exp_q.size());
         end
         if (bus.dds_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               checks++;
               if (act != exp) begin
                  errors++;
                  $display("FAIL sample actual=%0d expected=%0d", act, exp);
               end
            end
            if (act > obs_max) obs_max = act;
            if (act < obs_min) obs_min = act;
            last_out = act;
         end else begin
            checks++;
            if (act != last_out) begin
               errors++;
               $display("FAIL hold actual=%0d expected=%0d", act, last_out);
            end
         end
      end
   end

   initial begin
      int zeros;
      rstn          = 1'b0;
      bus.dds_en    = 1'b0;
      bus.phase_clr = 1'b0;
      bus.dds_fword = 32'h0;
      bus.dds_pword = 32'h0;
      bus.dds_amp   = 32'h0;
      obs_max       = -100000;
      obs_min       = 100000;
      last_out      = 0;
      repeat (3) step();
      rstn = 1'b1;
      step();
      chk("reset_out", int'($signed(bus.dds_out)), 0);
      chk("reset_valid", longint'(bus.dds_valid), 0);
      chk("reset_phase", longint'(bus.dds_phase), 0);

      // Full-scale sweep, 256 samples per period
      bus.dds_en    = 1'b1;
      bus.dds_fword = 32'h0100_0000;
      bus.dds_amp   = 32'h0000_FFFF;
      repeat (4) step();
      chk("latency_before", longint'(bus.dds_valid), 0);
      step();
      chk("latency_at5", longint'(bus.dds_valid), 1);
      obs_max = -100000;
      obs_min = 100000;
      repeat (300) step();
      chk("full_max", obs_max, 2046);
      chk("full_min", obs_min, -2047);

      // Half amplitude
      bus.dds_amp = 32'h0000_8000;
      repeat (6) step();
      obs_max = -100000;
      obs_min = 100000;
      repeat (300) step();
      chk("half_max", obs_max, 1023);
      chk("half_min", obs_min, -1024);

      // Constant quarter-phase offset
      bus.dds_amp   = 32'h0000_FFFF;
      bus.dds_fword = 32'h0;
      bus.dds_pword = 32'h4000_0000;
      bus.phase_clr = 1'b1;
      step();
      bus.phase_clr = 1'b0;
      repeat (8) step();
      chk("const_quarter", int'($signed(bus.dds_out)), 2046);

      // Accumulator wrap
      bus.phase_clr = 1'b1;
      bus.dds_en    = 1'b0;
      step();
      bus.phase_clr = 1'b0;
      bus.dds_en    = 1'b1;
      bus.dds_fword = 32'hFFFF_FFFF;
      step();
      chk("wrap_1", longint'(bus.dds_phase), longint'(32'hFFFF_FFFF));
      step();
      chk("wrap_2", longint'(bus.dds_phase), longint'(32'hFFFF_FFFE));
      step();
      chk("wrap_3", longint'(bus.dds_phase), longint'(32'hFFFF_FFFD));

      // Clear overriding enable, then a two-cycle enable gap
      bus.phase_clr = 1'b1;
      bus.dds_fword = 32'h0;
      step();
      bus.phase_clr = 1'b0;
      bus.dds_fword = 32'h1234_5678;
      step();
      chk("acc_preset", longint'(bus.dds_phase), longint'(32'h1234_5678));
      bus.phase_clr = 1'b1;
      step();
      chk("clr_over_en", longint'(bus.dds_phase), 0);
      bus.phase_clr = 1'b0;
      bus.dds_en    = 1'b0;
      zeros = 0;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (bus.dds_valid == 1'b0) zeros++;
         if (i == 2) bus.dds_en = 1'b1;
      end
      chk("gap_valid_low", zeros, 2);

      // Randomised traffic
      for (int i = 0; i < 500; i++) begin
         bus.dds_en    = ($urandom_range(0, 9) < 8);
         bus.phase_clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 4) == 0) bus.dds_fword = $urandom;
         if ($urandom_range(0, 9) == 0) bus.dds_pword = $urandom;
         if ($urandom_range(0, 9) == 0) bus.dds_amp = $urandom;
         step();
      end

      // Asynchronous reset in the middle of a sweep
      bus.dds_en    = 1'b1;
      bus.phase_clr = 1'b0;
      bus.dds_fword = 32'h0137_9AC5;
      bus.dds_amp   = 32'h0000_F000;
      repeat (20) step();
      rstn = 1'b0;
      #1;
      chk("async_out", int'($signed(bus.dds_out)), 0);
      chk("async_valid", longint'(bus.dds_valid), 0);
      chk("async_phase", longint'(bus.dds_phase), 0);
      repeat (2) step();
      rstn = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) bus.dds_pword = $urandom;
         step();
      end

      bus.dds_en = 1'b0;
      repeat (8) step();
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
